key_sw_io_port: RTL and testbench



---
 rtl/key_sw_io_port.sv | 128 ++++++++++++
 tb/tb_key_sw_io_port.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/key_sw_io_port.sv
// key_sw_io_port: CPU-readable input peripheral for the I/O window.
// It synchronizes and debounces the KEY buttons and synchronizes the SW
// switches. Key presses are captured as sticky write-1-to-clear event flags,
// and those flags drive a maskable interrupt.
//
// Ports:
//   clk, reset_n   single clock; synchronous active-low reset
//   key_n_in       raw KEY pins (0 = pressed), asynchronous
//   sw_in          raw SW pins, asynchronous
//   io_sel/io_addr/io_we/io_wdata  CPU access to the I/O window
//   io_rdata       combinational read data (0 when unselected or no hit)
//   key_level      debounced key state, 1 = pressed
//   irq            |(key_evt & evt_mask)
//
// Register map (one-hot address bits):
//   addr[4] KEY_LEVEL R, addr[5] SW R, addr[6] KEY_EVT R/W1C, addr[7] EVT_MASK R/W

// Per-key lane: two-flop synchronizer plus debounce counter.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta, sync;
  logic [CW-1:0] cnt;
  logic          pressed;

  assign pressed = ~sync;
  // level is about to go 0->1 on this edge
  assign rise    = ~level & pressed & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Sync flops reset to "released" so a key held through reset
      // is seen as a fresh press once reset drops.
      meta  <= 1'b1;
      sync  <= 1'b1;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta <= key_n;
      sync <= meta;
      if (pressed == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= pressed;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module key_sw_io_port #(
  parameter int NKEYS           = 4,
  parameter int NSW             = 10,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] key_n_in,
  input  logic [NSW-1:0]   sw_in,
  input  logic             io_sel,
  input  logic [8:0]       io_addr,
  input  logic             io_we,
  input  logic [31:0]      io_wdata,
  output logic [31:0]      io_rdata,
  output logic [NKEYS-1:0] key_level,
  output logic             irq
);
  logic [NKEYS-1:0] key_rise;
  logic [NKEYS-1:0] key_evt, evt_mask;
  logic [NSW-1:0]   sw_meta, sw_sync;
  logic             wr_evt, wr_mask;

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .key_n   (key_n_in[k]),
      .level   (key_level[k]),
      .rise    (key_rise[k])
    );
  end

  // Write decode is per address bit, so one access may hit both registers.
  assign wr_evt  = io_sel & io_we & io_addr[6];
  assign wr_mask = io_sel & io_we & io_addr[7];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_evt  <= '0;
      evt_mask <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      // Set is OR-ed after the clear so a press landing with a clear is kept.
      key_evt <= (wr_evt ? (key_evt & ~io_wdata[NKEYS-1:0]) : key_evt) | key_rise;
      if (wr_mask) evt_mask <= io_wdata[NKEYS-1:0];
    end
  end

  assign irq = |(key_evt & evt_mask);

  always_comb begin
    io_rdata = '0;
    if (io_sel) begin
      if (io_addr[4])      io_rdata[NKEYS-1:0] = key_level;
      else if (io_addr[5]) io_rdata[NSW-1:0]   = sw_sync;
      else if (io_addr[6]) io_rdata[NKEYS-1:0] = key_evt;
      else if (io_addr[7]) io_rdata[NKEYS-1:0] = evt_mask;
    end
  end

  // Address/data bits outside the decoded set are intentionally ignored.
  logic unused;
  assign unused = ^{io_addr[8], io_addr[3:0], io_wdata[31:NKEYS]};
endmodule

// File: tb/tb_key_sw_io_port.sv
// Bench for key_sw_io_port: expected read values are pushed to a scoreboard
// queue as stimulus is applied and popped when the register is read back.
module tb_key_sw_io_port;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  key_n_in;
  logic [9:0]  sw_in;
  logic        io_sel;
  logic [8:0]  io_addr;
  logic        io_we;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic [3:0]  key_level;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, exp;

  key_sw_io_port #(.NKEYS(4), .NSW(10), .DEBOUNCE_CYCLES(3)) dut (
    .clk(clk), .reset_n(reset_n), .key_n_in(key_n_in), .sw_in(sw_in),
    .io_sel(io_sel), .io_addr(io_addr), .io_we(io_we), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .key_level(key_level), .irq(irq)
  );

  always #5 clk = ~clk;

  // Drive a read at the current time; results are compared by the caller.
  task automatic rd(input logic [8:0] a, output logic [31:0] d);
    io_sel = 1'b1; io_addr = a; io_we = 1'b0;
    #1;
    d = io_rdata;
    io_sel = 1'b0;
  endtask

  // One-cycle write, issued at a negedge; returns at the following negedge.
  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    io_sel = 1'b1; io_addr = a; io_we = 1'b1; io_wdata = d;
    @(negedge clk);
    io_we = 1'b0; io_sel = 1'b0; io_wdata = '0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; key_n_in = 4'hF; sw_in = '0;
    io_sel = 0; io_addr = '0; io_we = 0; io_wdata = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (key_level !== 4'h0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_outs level=%h irq=%b want 0/0", key_level, irq);
    end
    exp_q.push_back(32'h0); rd(9'h140, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_evt got=%h want=%h", got, exp); end
    exp_q.push_back(32'h0); rd(9'h180, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_mask got=%h want=%h", got, exp); end
    reset_n = 1'b1;
  endtask

  task automatic test_press_latency;
    @(negedge clk);
    key_n_in = 4'b1101;
    exp_q.push_back(32'h2); exp_q.push_back(32'h2);
    repeat (4) @(negedge clk);
    n_tests++;
    if (key_level !== 4'h0) begin n_fail++; $display("FAIL press_early level=%h want=0", key_level); end
    @(negedge clk);
    n_tests++;
    if (key_level !== 4'h2) begin n_fail++; $display("FAIL press_c5 level=%h want=2", key_level); end
    rd(9'h110, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL press_lvl_rd got=%h want=%h", got, exp); end
    rd(9'h140, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL press_evt_rd got=%h want=%h", got, exp); end
  endtask

  task automatic test_glitch;
    @(negedge clk);
    key_n_in = 4'b1001;
    repeat (2) @(negedge clk);
    key_n_in = 4'b1101;
    exp_q.push_back(32'h2);
    repeat (10) @(negedge clk);
    n_tests++;
    if (key_level !== 4'h2) begin n_fail++; $display("FAIL glitch_level got=%h want=2", key_level); end
    rd(9'h140, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch_evt got=%h want=%h", got, exp); end
  endtask

  task automatic test_w1c;
    key_n_in = 4'b0101;
    repeat (6) @(negedge clk);
    key_n_in = 4'hF;
    exp_q.push_back(32'hA);
    repeat (6) @(negedge clk);
    n_tests++;
    if (key_level !== 4'h0) begin n_fail++; $display("FAIL release_level got=%h want=0", key_level); end
    rd(9'h140, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL w1c_before got=%h want=%h", got, exp); end
    wr(9'h140, 32'h8); exp_q.push_back(32'h2);
    rd(9'h140, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL w1c_clear8 got=%h want=%h", got, exp); end
    @(negedge clk);
    wr(9'h140, 32'h0); exp_q.push_back(32'h2);
    rd(9'h140, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL w1c_zero got=%h want=%h", got, exp); end
  endtask

  task automatic test_irq_set_wins;
    @(negedge clk);
    wr(9'h180, 32'h1); exp_q.push_back(32'h1);
    rd(9'h180, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL mask_rd got=%h want=%h", got, exp); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got=%b want=0", irq); end
    key_n_in = 4'hE;
    repeat (5) @(negedge clk);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_on_press got=%b want=1", irq); end
    wr(9'h140, 32'h1);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_clr got=%b want=0", irq); end
    key_n_in = 4'hF;
    repeat (6) @(negedge clk);
    key_n_in = 4'hE;
    exp_q.push_back(32'h3);
    repeat (4) @(negedge clk);
    wr(9'h140, 32'h1);   // clear lands on the same edge as the new press
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq got=%b want=1", irq); end
    rd(9'h140, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL set_wins_evt got=%h want=%h", got, exp); end
  endtask

  task automatic test_sw_and_decode;
    @(negedge clk);
    sw_in = 10'h2A5;
    exp_q.push_back(32'h0); exp_q.push_back(32'h2A5);
    @(negedge clk);
    rd(9'h120, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sw_1cyc got=%h want=%h", got, exp); end
    @(negedge clk);
    rd(9'h120, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sw_2cyc got=%h want=%h", got, exp); end
    io_sel = 1'b0; io_addr = 9'h120; #1; n_tests++;
    if (io_rdata !== 32'h0) begin n_fail++; $display("FAIL unselected got=%h want=0", io_rdata); end
    exp_q.push_back(32'h1);
    rd(9'h130, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL prio_130 got=%h want=%h", got, exp); end
    exp_q.push_back(32'h3);
    rd(9'h1C0, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL prio_1c0 got=%h want=%h", got, exp); end
    @(negedge clk);
    wr(9'h1C0, 32'h2);   // clears evt bit1 and sets mask to 0x2
    exp_q.push_back(32'h2); exp_q.push_back(32'h1);
    rd(9'h180, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL dual_wr_mask got=%h want=%h", got, exp); end
    rd(9'h140, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL dual_wr_evt got=%h want=%h", got, exp); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL dual_wr_irq got=%b want=0", irq); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    key_n_in = 4'h0;
    exp_q.push_back(32'hF);
    repeat (6) @(negedge clk);
    rd(9'h140, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL all_evt got=%h want=%h", got, exp); end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_rst_irq got=%b want=1", irq); end
    @(negedge clk);
    key_n_in = 4'h8;     // key3 released: its count is at 2 four edges later
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_tests++;
    if (key_level !== 4'h0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outs level=%h irq=%b want 0/0", key_level, irq);
    end
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    rd(9'h140, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_evt got=%h want=%h", got, exp); end
    rd(9'h180, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_mask got=%h want=%h", got, exp); end
    rd(9'h120, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_mid_sw got=%h want=%h", got, exp); end
    exp_q.push_back(32'h7);
    repeat (4) @(negedge clk);
    n_tests++;
    if (key_level !== 4'h0) begin n_fail++; $display("FAIL redetect_early got=%h want=0", key_level); end
    @(negedge clk);
    n_tests++;
    if (key_level !== 4'h7) begin n_fail++; $display("FAIL redetect_level got=%h want=7", key_level); end
    rd(9'h140, got); exp = exp_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL redetect_evt got=%h want=%h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_w1c();
    test_irq_set_wins();
    test_sw_and_decode();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
